// File: rtl/priority_grant_2x1_fsm.sv
// priority_grant_2x1_fsm
// Grants a shared resource to one of two requesters, chosen by an upstream
// 2x1 priority encoder. A grant ends when the owner raises done, or when it
// has lasted MAX_HOLD cycles. One RELEASE cycle always follows a grant, so
// the resource is idle for at least two cycles between grants.
// All outputs are registered, so no input reaches an output in the same cycle.

module priority_grant_2x1_fsm #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_out,
   input  logic       enc_valid,
   input  logic       done,
   output logic [1:0] gnt,
   output logic       gnt_idx,
   output logic       busy,
   output logic       timeout,
   output logic [3:0] hold_cnt
);

   // hold_cnt value of the final cycle a grant may last
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT   = 2'b01,
      RELEASE = 2'b10
   } state_t;

   state_t     r_state;
   logic [1:0] r_gnt;
   logic       r_gntIdx;
   logic       r_busy;
   logic       r_timeout;
   logic [3:0] r_holdCnt;
   logic       w_holdExpired;

   assign w_holdExpired = (r_holdCnt == HOLD_LAST);

   assign gnt      = r_gnt;
   assign gnt_idx  = r_gntIdx;
   assign busy     = r_busy;
   assign timeout  = r_timeout;
   assign hold_cnt = r_holdCnt;

   // State machine and all registered outputs; reset overrides every state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= 2'b00;
         r_gntIdx  <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_holdCnt <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (enc_valid) begin
                  r_state   <= GRANT;
                  r_gntIdx  <= enc_out;
                  r_gnt     <= enc_out ? 2'b10 : 2'b01;
                  r_busy    <= 1'b1;
                  r_holdCnt <= 4'd0;
               end else begin
                  r_gnt  <= 2'b00;
                  r_busy <= 1'b0;
               end
            end
            GRANT: begin
               if (done) begin
                  r_state   <= RELEASE;
                  r_gnt     <= 2'b00;
                  r_timeout <= 1'b0;
               end else if (w_holdExpired) begin
                  r_state   <= RELEASE;
                  r_gnt     <= 2'b00;
                  r_timeout <= 1'b1;
               end else begin
                  r_holdCnt <= r_holdCnt + 4'd1;
               end
            end
            RELEASE: begin
               r_state   <= IDLE;
               r_gnt     <= 2'b00;
               r_busy    <= 1'b0;
               r_timeout <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_gnt     <= 2'b00;
               r_gntIdx  <= 1'b0;
               r_busy    <= 1'b0;
               r_timeout <= 1'b0;
               r_holdCnt <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_priority_grant_2x1_fsm.sv
// tb_priority_grant_2x1_fsm
// Drives directed scenarios followed by random traffic into the grant FSM
// and compares every output, every cycle, against a cycle-level reference
// model built from grant/release bookkeeping rather than state codes.

module tb_priority_grant_2x1_fsm;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst;
   logic       enc_out;
   logic       enc_valid;
   logic       done;
   logic [1:0] gnt;
   logic       gnt_idx;
   logic       busy;
   logic       timeout;
   logic [3:0] hold_cnt;

   int errorCount = 0;
   int checkCount = 0;

   // reference model state
   bit   mGranted;
   bit   mReleasing;
   logic [1:0] mGnt;
   logic mIdx;
   logic mBusy;
   logic mTimeout;
   int   mHold;

   priority_grant_2x1_fsm #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .enc_out  (enc_out),
      .enc_valid(enc_valid),
      .done     (done),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .busy     (busy),
      .timeout  (timeout),
      .hold_cnt (hold_cnt)
   );

   // free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // what the outputs should be after one edge with these inputs
   task automatic modelStep(input logic r, input logic v, input logic o, input logic d);
      if (r) begin
         mGranted = 0; mReleasing = 0;
         mGnt = 2'b00; mIdx = 1'b0; mBusy = 1'b0; mTimeout = 1'b0; mHold = 0;
      end else if (mGranted) begin
         if (d || (mHold + 1 == MAX_HOLD)) begin
            mGranted   = 0;
            mReleasing = 1;
            mGnt       = 2'b00;
            mBusy      = 1'b1;
            mTimeout   = !d;
         end else begin
            mHold = mHold + 1;
         end
      end else if (mReleasing) begin
         mReleasing = 0;
         mBusy      = 1'b0;
         mTimeout   = 1'b0;
      end else if (v) begin
         mGranted = 1;
         mIdx     = o;
         mGnt     = 2'(1 << o);
         mHold    = 0;
         mBusy    = 1'b1;
         mTimeout = 1'b0;
      end
   endtask

   // drive one cycle of inputs, advance the model, then compare after the edge
   task automatic applyStimulus(input logic r, input logic v, input logic o, input logic d);
      rst = r; enc_valid = v; enc_out = o; done = d;
      modelStep(r, v, o, d);
      @(posedge clk);
      #1;
      checkOutput("gnt",      32'(gnt),      32'(mGnt));
      checkOutput("gnt_idx",  32'(gnt_idx),  32'(mIdx));
      checkOutput("busy",     32'(busy),     32'(mBusy));
      checkOutput("timeout",  32'(timeout),  32'(mTimeout));
      checkOutput("hold_cnt", 32'(hold_cnt), 32'(mHold));
   endtask

   initial begin
      rst = 1'b1; enc_valid = 1'b0; enc_out = 1'b0; done = 1'b0;
      #2;

      // reset state
      applyStimulus(1, 1, 1, 1);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      applyStimulus(0, 0, 1, 1);

      // scenario 1: grant to requester 1
      applyStimulus(0, 1, 1, 0);
      checkOutput("s1_gnt", 32'(gnt), 32'b10);
      checkOutput("s1_idx", 32'(gnt_idx), 32'd1);
      checkOutput("s1_hold", 32'(hold_cnt), 32'd0);

      // scenario 2 and 5: enc_out flips while granted, done at hold_cnt=2
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("s5_gnt_held", 32'(gnt), 32'b10);
      applyStimulus(0, 1, 0, 1);
      checkOutput("s2_rel_gnt", 32'(gnt), 32'd0);
      checkOutput("s2_rel_busy", 32'(busy), 32'd1);
      checkOutput("s2_rel_hold", 32'(hold_cnt), 32'd2);
      applyStimulus(0, 1, 0, 0);
      checkOutput("s2_idle_busy", 32'(busy), 32'd0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("s5_regrant", 32'(gnt), 32'b01);

      // scenario 3: full-length grant ending in timeout
      for (int i = 0; i < MAX_HOLD - 1; i++) applyStimulus(0, 0, 0, 0);
      checkOutput("s3_last_hold", 32'(hold_cnt), 32'(MAX_HOLD - 1));
      applyStimulus(0, 0, 0, 0);
      checkOutput("s3_timeout", 32'(timeout), 32'd1);
      applyStimulus(0, 0, 0, 0);
      checkOutput("s3_timeout_clr", 32'(timeout), 32'd0);

      // scenario 4: done coincides with the last hold cycle
      applyStimulus(0, 1, 1, 0);
      for (int i = 0; i < MAX_HOLD - 1; i++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("s4_timeout", 32'(timeout), 32'd0);
      applyStimulus(0, 0, 0, 0);

      // scenario 6: reset mid-grant, then regrant right after
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(1, 1, 1, 0);
      checkOutput("s6_gnt", 32'(gnt), 32'd0);
      checkOutput("s6_busy", 32'(busy), 32'd0);
      applyStimulus(0, 1, 1, 0);
      checkOutput("s6_regrant", 32'(gnt), 32'b10);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(99) < 3) ? 1'b1 : 1'b0,
                       ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
                       1'($urandom),
                       ($urandom_range(99) < 15) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
